// File: rtl/karatsuba_seq_ctrl.sv
// Sequential 64x64 unsigned multiplier controller: three Karatsuba partial
// products are computed on one shared external 34x34 multiplier, then combined.
module karatsuba_seq_ctrl #(
  parameter int MUL_LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  x,
  input  logic [63:0]  y,
  output logic [33:0]  mul_x,
  output logic [33:0]  mul_y,
  input  logic [67:0]  mul_p,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] p,
  output logic [15:0]  op_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_Z0   = 3'd1;
  localparam logic [2:0] S_Z2   = 3'd2;
  localparam logic [2:0] S_Z1   = 3'd3;
  localparam logic [2:0] S_COMB = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam int CW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   x_q, x_d, y_q, y_d;
  logic [67:0]   z0_q, z0_d, z2_q, z2_d, z1_q, z1_d;
  logic [127:0]  p_q, p_d;
  logic [33:0]   mul_x_q, mul_x_d, mul_y_q, mul_y_d;
  logic [15:0]   op_count_q, op_count_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic          last_s;
  logic [127:0]  mid_s;
  logic [32:0]   sum_x_s, sum_y_s;

  assign last_s = (cnt_q == CNT_LAST);

  // Next-state, capture and combine logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    z0_d       = z0_q;
    z2_d       = z2_q;
    z1_d       = z1_q;
    p_d        = p_q;
    op_count_d = op_count_q;
    mid_s      = {60'd0, z1_q} - {60'd0, z0_q} - {60'd0, z2_q};

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = x;
          y_d     = y;
          cnt_d   = {CW{1'b0}};
          state_d = S_Z0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_Z0: begin
        if (last_s) begin
          z0_d    = mul_p;
          cnt_d   = {CW{1'b0}};
          state_d = S_Z2;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_Z2: begin
        if (last_s) begin
          z2_d    = mul_p;
          cnt_d   = {CW{1'b0}};
          state_d = S_Z1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_Z1: begin
        if (last_s) begin
          z1_d    = mul_p;
          cnt_d   = {CW{1'b0}};
          state_d = S_COMB;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_COMB: begin
        p_d     = ({60'd0, z2_q} << 64) + (mid_s << 32) + {60'd0, z0_q};
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          if (op_count_q != 16'hFFFF) begin
            op_count_d = op_count_q + 16'd1;
          end else begin
            op_count_d = op_count_q;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // Multiplier operands and handshake flags are decoded from the next state so they are registered.
  always_comb begin
    sum_x_s     = {1'b0, x_d[31:0]} + {1'b0, x_d[63:32]};
    sum_y_s     = {1'b0, y_d[31:0]} + {1'b0, y_d[63:32]};
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    case (state_d)
      S_Z0: begin
        mul_x_d = {2'b00, x_d[31:0]};
        mul_y_d = {2'b00, y_d[31:0]};
      end
      S_Z2: begin
        mul_x_d = {2'b00, x_d[63:32]};
        mul_y_d = {2'b00, y_d[63:32]};
      end
      S_Z1: begin
        mul_x_d = {1'b0, sum_x_s};
        mul_y_d = {1'b0, sum_y_s};
      end
      default: begin
        mul_x_d = 34'd0;
        mul_y_d = 34'd0;
      end
    endcase
  end

  // State register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CW{1'b0}};
      x_q         <= 64'd0;
      y_q         <= 64'd0;
      z0_q        <= 68'd0;
      z2_q        <= 68'd0;
      z1_q        <= 68'd0;
      p_q         <= 128'd0;
      mul_x_q     <= 34'd0;
      mul_y_q     <= 34'd0;
      op_count_q  <= 16'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z0_q        <= z0_d;
      z2_q        <= z2_d;
      z1_q        <= z1_d;
      p_q         <= p_d;
      mul_x_q     <= mul_x_d;
      mul_y_q     <= mul_y_d;
      op_count_q  <= op_count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign op_count  = op_count_q;

endmodule

// File: doc/karatsuba_seq_ctrl.md
KARATSUBA_SEQ_CTRL -- requirements
Module: karatsuba_seq_ctrl

Interface
REQ-001 The block SHALL have parameter MUL_LAT, default 0: the external multiplier's latency in cycles, with mul_p valid MUL_LAT cycles after its operands (0 = combinational).
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1: operand pair offered.
REQ-005 The block SHALL have port in_ready, output, 1: block accepts operands this cycle.
REQ-006 The block SHALL have ports x and y, input, 64 each: unsigned operands.
REQ-007 The block SHALL have port mul_x, output, 34: multiplicand to the shared 34x34 multiplier.
REQ-008 The block SHALL have port mul_y, output, 34: multiplier operand to the shared 34x34 multiplier.
REQ-009 The block SHALL have port mul_p, input, 68: product returned by the multiplier.
REQ-010 The block SHALL have port out_valid, output, 1: result available.
REQ-011 The block SHALL have port out_ready, input, 1: consumer accepts result.
REQ-012 The block SHALL have port p, output, 128: product result.
REQ-013 The block SHALL have port op_count, output, 16: completed-result counter, saturating.

Function
REQ-014 The block SHALL implement states IDLE, Z0, Z2, Z1, COMB, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; in IDLE, in_valid=1 captures x and y at the edge, and the state moves to Z0.
REQ-016 Operand split SHALL be xl=x[31:0], xh=x[63:32], yl=y[31:0], yh=y[63:32].
REQ-017 Multiplier operands SHALL be zero-extended to 34 bits:
- Z0: mul_x=xl, mul_y=yl
- Z2: mul_x=xh, mul_y=yh
- Z1: mul_x=xl+xh, mul_y=yl+yh (33-bit sums)
- all other states: mul_x=mul_y=0
REQ-018 Each of Z0, Z2 and Z1 SHALL last exactly MUL_LAT+1 cycles, counted by an internal counter; mul_x and mul_y SHALL be held constant for the whole state.
REQ-019 mul_p SHALL be captured into a 68-bit register (z0, z2 or z1) only on the last cycle of its state; mul_p is ignored on all other cycles.
REQ-020 Transitions Z0->Z2->Z1->COMB SHALL occur unconditionally on completion of each state; COMB SHALL last 1 cycle, then go to DONE.
REQ-021 In COMB, the block SHALL compute mid=z1-z0-z2 and p=(z2<<64)+(mid<<32)+z0, all arithmetic modulo 2^128 on zero-extended values, and SHALL register p.
- With an exact multiplier, p SHALL equal x*y.
- With an approximate multiplier, the block SHALL NOT correct the multiplier's error.
REQ-022 out_valid SHALL be 1 exactly in DONE; p SHALL hold stable while out_valid=1.
REQ-023 In DONE with out_ready=1, the block SHALL return to IDLE and increment op_count (saturating at 0xFFFF); there is no acceptance in the same cycle as DONE.
REQ-024 Latency: out_valid SHALL rise 3*(MUL_LAT+1)+1 rising edges after the accepting edge (4 for MUL_LAT=0).
REQ-025 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE.

Reset
REQ-026 While rst=1, regardless of clk, the block SHALL force: state=IDLE, in_ready=1, out_valid=0, p=0, mul_x=0, mul_y=0, op_count=0, operand/product registers=0, latency counter=0.
REQ-027 Reset asserted mid-operation SHALL abandon the operation, with no out_valid and no op_count change; after release, the next accepted pair SHALL compute correctly.

Verification (bench uses an exact behavioural multiplier with configurable latency)
REQ-028 The bench SHALL cover: MUL_LAT=0, x=3, y=5, out_ready=1 -> out_valid at edge 4 after accept, p=15, op_count=1.
REQ-029 The bench SHALL cover: x=y=0xFFFF_FFFF_FFFF_FFFF -> mul operands FFFFFFFF/FFFFFFFF (Z0), FFFFFFFF/FFFFFFFF (Z2), 1_FFFFFFFE/1_FFFFFFFE (Z1); p=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
REQ-030 The bench SHALL cover: out_ready=0 for 10 cycles in DONE, with in_valid=1 -> out_valid and p stable, in_ready=0, no new capture; out_ready=1 -> IDLE next cycle.
REQ-031 The bench SHALL cover: MUL_LAT=2, with mul_p driven to garbage on non-sampling cycles -> latency 10 edges, p=x*y for x=0x1234_5678_9ABC_DEF0, y=0x0FED_CBA9_8765_4321.
REQ-032 The bench SHALL cover: rst pulsed during Z2 -> all outputs zero immediately, no out_valid; then x=2^32, y=2^32 -> p=2^64, op_count=1.
